// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: funct3 codes, access sizes, writeback
// select values, the bus FSM state type and the debug filler pattern.
package mem_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size lives in funct3[1:0]; anything that is not byte or half is a word.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    localparam logic [1:0] WB_SEL_ALU     = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD    = 2'b01;
    localparam logic [1:0] WB_SEL_PC4     = 2'b10;
    localparam logic [1:0] WB_SEL_ALU_ALT = 2'b11;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_RSP = 1'b1
    } mem_state_e;

    localparam logic [31:0] DBG_FILL_WDATA = 32'hA1A1_A1A1;

endpackage

// File: rtl/load_store_aligner.sv
// Combinational lane steering: byte enables and replicated store data on the way
// out, shifted and sign/zero-extended load data on the way back.
module load_store_aligner
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        is_store_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [1:0]  addr_lo_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [1:0]  off;
    logic [31:0] shifted;

    always_comb begin
        // Low address bits below the access size are dropped, so a misaligned
        // half or word silently becomes the aligned one containing it.
        off = addr_lo_i;
        if (funct3_i[1:0] == SIZE_HALF) begin
            off = {addr_lo_i[1], 1'b0};
        end else if (funct3_i[1:0] != SIZE_BYTE) begin
            off = 2'b00;
        end
        addr_lo_o = off;
        shifted   = rdata_i >> {off, 3'b000};

        be_o    = 4'b1111;
        wdata_o = DBG_FILL_WDATA;
        if (is_store_i) begin
            case (funct3_i)
                F3_SB: begin
                    be_o    = 4'b0001 << off;
                    wdata_o = {4{store_data_i[7:0]}};
                end
                F3_SH: begin
                    be_o    = 4'b0011 << off;
                    wdata_o = {2{store_data_i[15:0]}};
                end
                default: begin
                    be_o    = 4'b1111;
                    wdata_o = store_data_i;
                end
            endcase
        end

        case (funct3_i)
            F3_LB:   load_data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_data_o = {24'h0, shifted[7:0]};
            F3_LHU:  load_data_o = {16'h0, shifted[15:0]};
            default: load_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// MEM stage: runs one req/gnt then rvalid transaction per load/store, stalls upstream
// while it is outstanding, and holds the MEM/WB register. MEM_MISALIGN_TRAP_EN turns
// misaligned half/word accesses into a misalign pulse instead of silent alignment.
module memory_access
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int XLEN       = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [XLEN-1:0]       alu_result_mem_i,
    input  logic [XLEN-1:0]       latest_rs2_value_mem_i,
    input  logic                  load_store_forward_sel_mem_i,
    input  logic                  reg_write_en_mem_i,
    input  logic                  is_load_instr_mem_i,
    input  logic                  is_store_instr_mem_i,
    input  logic [4:0]            rd_label_mem_i,
    input  logic [1:0]            wb_sel_mem_i,
    input  logic [XLEN-1:0]       pc_mem_i,
    input  logic [2:0]            funct3_mem_i,
    output logic                  dmem_req_o,
    input  logic                  dmem_gnt_i,
    output logic                  dmem_we_o,
    output logic [3:0]            dmem_be_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [XLEN-1:0]       dmem_wdata_o,
    input  logic                  dmem_rvalid_i,
    input  logic [XLEN-1:0]       dmem_rdata_i,
    output logic [XLEN-1:0]       rd_value_mem_o,
    output logic                  mem_stall_o,
    output logic                  misalign_o,
    output logic                  reg_write_en_wb_o,
    output logic [4:0]            rd_label_wb_o,
    output logic [XLEN-1:0]       rd_value_wb_o
);

    mem_state_e      state_q, state_d;
    logic            mem_op, mem_go, misaligned;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] store_src, load_data;
    logic            reg_write_en_d, reg_write_en_q;
    logic            misalign_d, misalign_q;
    logic [4:0]      rd_label_d, rd_label_q;
    logic [XLEN-1:0] rd_value_d, rd_value_q;

    assign mem_op = is_load_instr_mem_i | is_store_instr_mem_i;

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        if (mem_op) begin
            if (funct3_mem_i[1:0] == SIZE_HALF) begin
                misaligned = alu_result_mem_i[0];
            end else if (funct3_mem_i[1:0] != SIZE_BYTE) begin
                misaligned = |alu_result_mem_i[1:0];
            end
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    assign mem_go    = mem_op & ~misaligned;
    assign store_src = load_store_forward_sel_mem_i ? rd_value_q : latest_rs2_value_mem_i;

    load_store_aligner u_aligner (
        .funct3_i     (funct3_mem_i),
        .is_store_i   (is_store_instr_mem_i),
        .addr_lo_i    (alu_result_mem_i[1:0]),
        .store_data_i (store_src),
        .rdata_i      (dmem_rdata_i),
        .addr_lo_o    (addr_lo),
        .be_o         (dmem_be_o),
        .wdata_o      (dmem_wdata_o),
        .load_data_o  (load_data)
    );

    assign dmem_addr_o = {alu_result_mem_i[ADDR_WIDTH-1:2], addr_lo};
    assign dmem_we_o   = is_store_instr_mem_i;
    assign mem_stall_o = mem_go & ~((state_q == ST_WAIT_RSP) & dmem_rvalid_i);

    // Stores wait for rvalid too, so both kinds share one request/response path.
    always_comb begin
        state_d    = state_q;
        dmem_req_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                dmem_req_o = mem_go;
                if (mem_go && dmem_gnt_i) begin
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (dmem_rvalid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (wb_sel_mem_i)
            WB_SEL_LOAD: rd_value_mem_o = load_data;
            WB_SEL_PC4:  rd_value_mem_o = pc_mem_i + XLEN'(4);
            default:     rd_value_mem_o = alu_result_mem_i;
        endcase
    end

    // MEM/WB holds while stalled so WB forwarding and the repeated write stay valid.
    always_comb begin
        reg_write_en_d = reg_write_en_q;
        rd_label_d     = rd_label_q;
        rd_value_d     = rd_value_q;
        misalign_d     = misalign_q;
        if (!mem_stall_o) begin
            reg_write_en_d = reg_write_en_mem_i & ~misaligned;
            rd_label_d     = rd_label_mem_i;
            rd_value_d     = rd_value_mem_o;
            misalign_d     = misaligned;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            reg_write_en_q <= 1'b0;
            rd_label_q     <= '0;
            rd_value_q     <= '0;
            misalign_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            reg_write_en_q <= reg_write_en_d;
            rd_label_q     <= rd_label_d;
            rd_value_q     <= rd_value_d;
            misalign_q     <= misalign_d;
        end
    end

    assign reg_write_en_wb_o = reg_write_en_q;
    assign rd_label_wb_o     = rd_label_q;
    assign rd_value_wb_o     = rd_value_q;
    assign misalign_o        = misalign_q;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed scenarios with literal expectations, then random
// instructions and bus timing checked every cycle against a transaction-level model.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_result, rs2_value, pc;
    logic        fwd_sel, wen_in, is_load, is_store;
    logic [4:0]  rd_in;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic        req, gnt, we, rvalid;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata, rd_value_mem;
    logic        stall, misalign, wen_wb;
    logic [4:0]  label_wb;
    logic [31:0] value_wb;

    memory_access dut (
        .clk_i                        (clk),
        .rst_ni                       (rst_n),
        .alu_result_mem_i             (alu_result),
        .latest_rs2_value_mem_i       (rs2_value),
        .load_store_forward_sel_mem_i (fwd_sel),
        .reg_write_en_mem_i           (wen_in),
        .is_load_instr_mem_i          (is_load),
        .is_store_instr_mem_i         (is_store),
        .rd_label_mem_i               (rd_in),
        .wb_sel_mem_i                 (wb_sel),
        .pc_mem_i                     (pc),
        .funct3_mem_i                 (funct3),
        .dmem_req_o                   (req),
        .dmem_gnt_i                   (gnt),
        .dmem_we_o                    (we),
        .dmem_be_o                    (be),
        .dmem_addr_o                  (addr),
        .dmem_wdata_o                 (wdata),
        .dmem_rvalid_i                (rvalid),
        .dmem_rdata_i                 (rdata),
        .rd_value_mem_o               (rd_value_mem),
        .mem_stall_o                  (stall),
        .misalign_o                   (misalign),
        .reg_write_en_wb_o            (wen_wb),
        .rd_label_wb_o                (label_wb),
        .rd_value_wb_o                (value_wb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: whether the bus has accepted the current op, plus the expected MEM/WB contents.
    bit          m_out, m_stall, m_wen, m_mis;
    logic [4:0]  m_label;
    logic [31:0] m_val;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
        int nb;
        nb = size_of(f3);
        return (int'(a[1:0]) / nb) * nb;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] f3, input int off, input logic [31:0] rd);
        logic [31:0]        w;
        logic signed [31:0] sx;
        w = rd >> (8 * off);
        case (f3)
            3'b000: begin sx = $signed(w[7:0]);  return sx; end
            3'b001: begin sx = $signed(w[15:0]); return sx; end
            3'b100: return {24'h0, w[7:0]};
            3'b101: return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always @(negedge clk) begin : compare
        bit          memop, mis, active, exp_req, done;
        int          nb, off;
        logic [31:0] src, exp_wd, exp_fwd;
        logic [3:0]  exp_be;
        if (!rst_n) begin
            m_out   = 0;
            m_stall = 0;
            m_wen   = 0;
            m_mis   = 0;
            m_label = 0;
            m_val   = 0;
            checkOutput("rst_wen_wb", 32'(wen_wb), 32'd0);
            checkOutput("rst_label_wb", 32'(label_wb), 32'd0);
            checkOutput("rst_value_wb", value_wb, 32'd0);
            checkOutput("rst_misalign", 32'(misalign), 32'd0);
        end else begin
            memop = is_load || is_store;
            nb    = size_of(funct3);
            off   = lane_off(funct3, alu_result);
`ifdef MEM_MISALIGN_TRAP_EN
            mis = memop && ((int'(alu_result[1:0]) % nb) != 0);
`else
            mis = 0;
`endif
            active  = memop && !mis;
            exp_req = active && !m_out;
            done    = active && m_out && rvalid;
            m_stall = active && !done;
            checkOutput("req", 32'(req), 32'(exp_req));
            checkOutput("stall", 32'(stall), 32'(m_stall));
            if (exp_req) begin
                src    = fwd_sel ? m_val : rs2_value;
                exp_be = 4'hF;
                if (is_store) begin
                    exp_be = 4'h0;
                    for (int i = 0; i < 4; i++) begin
                        if (i >= off && i < off + nb) exp_be[i] = 1'b1;
                        exp_wd[8*i +: 8] = src[8*(i % nb) +: 8];
                    end
                    checkOutput("wdata", wdata, exp_wd);
                end
                checkOutput("be", 32'(be), 32'(exp_be));
                checkOutput("we", 32'(we), 32'(is_store));
                checkOutput("addr", addr, {alu_result[31:2], 2'b00} + 32'(off));
            end
            case (wb_sel)
                2'b01:   exp_fwd = load_value(funct3, off, rdata);
                2'b10:   exp_fwd = pc + 32'd4;
                default: exp_fwd = alu_result;
            endcase
            if (wb_sel != 2'b01 || done) checkOutput("fwd_value", rd_value_mem, exp_fwd);
            checkOutput("wen_wb", 32'(wen_wb), 32'(m_wen));
            checkOutput("label_wb", 32'(label_wb), 32'(m_label));
            checkOutput("value_wb", value_wb, m_val);
            checkOutput("misalign", 32'(misalign), 32'(m_mis));
            if (exp_req && gnt) m_out = 1;
            else if (m_out && rvalid) m_out = 0;
            if (!m_stall) begin
                m_wen   = wen_in && !mis;
                m_label = rd_in;
                m_val   = exp_fwd;
                m_mis   = mis;
            end
        end
    end

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit ld, input bit st, input bit wen, input bit fs,
                                 input logic [2:0] f3, input logic [1:0] ws, input logic [4:0] rd,
                                 input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pcv);
        is_load    = ld;
        is_store   = st;
        wen_in     = wen;
        fwd_sel    = fs;
        funct3     = f3;
        wb_sel     = ws;
        rd_in      = rd;
        alu_result = alu;
        rs2_value  = rs2;
        pc         = pcv;
    endtask

    task automatic setIdle();
        applyStimulus(0, 0, 0, 0, 3'b000, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic randomInstr();
        int kind;
        kind = $urandom_range(0, 2);
        applyStimulus(0, 0, 1'($urandom), 0, 3'($urandom), 2'b00, 5'($urandom),
                      $urandom, $urandom, $urandom & 32'hFFFF_FFFC);
        case (kind)
            0: wb_sel = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11);
            1: begin is_load = 1; wb_sel = 2'b01; end
            default: begin
                is_store = 1;
                funct3   = 3'($urandom_range(0, 2));
                fwd_sel  = 1'($urandom);
            end
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  stalls;
        bit  drained;
        rst_n = 0;
        setIdle();
        gnt    = 0;
        rvalid = 0;
        rdata  = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req", 32'(req), 32'd0);
        checkOutput("reset_value_wb", value_wb, 32'd0);
        stepEdge();
        rst_n = 1;

        // ALU result passes straight through, no stall
        stepEdge();
        applyStimulus(0, 0, 1, 0, 3'b000, 2'b00, 5'd5, 32'h0000_1234, 32'h0, 32'h100);
        @(negedge clk);
        checkOutput("alu_fwd", rd_value_mem, 32'h0000_1234);
        checkOutput("alu_stall", 32'(stall), 32'd0);
        stepEdge();
        setIdle();
        @(negedge clk);
        checkOutput("alu_wb_value", value_wb, 32'h0000_1234);
        checkOutput("alu_wb_wen", 32'(wen_wb), 32'd1);
        checkOutput("alu_wb_label", 32'(label_wb), 32'd5);

        // LB then LBU at 0x103
        stepEdge();
        applyStimulus(1, 0, 1, 0, 3'b000, 2'b01, 5'd7, 32'h0000_0103, 32'h0, 32'h0);
        gnt   = 1;
        rdata = 32'h80AA_BBCC;
        @(negedge clk);
        checkOutput("lb_req", 32'(req), 32'd1);
        checkOutput("lb_stall_first", 32'(stall), 32'd1);
        checkOutput("lb_be", 32'(be), 32'hF);
        stepEdge();
        gnt    = 0;
        rvalid = 1;
        @(negedge clk);
        checkOutput("lb_stall_done", 32'(stall), 32'd0);
        checkOutput("lb_fwd", rd_value_mem, 32'hFFFF_FF80);
        stepEdge();
        rvalid = 0;
        applyStimulus(1, 0, 1, 0, 3'b100, 2'b01, 5'd8, 32'h0000_0103, 32'h0, 32'h0);
        gnt = 1;
        @(negedge clk);
        checkOutput("lb_wb_value", value_wb, 32'hFFFF_FF80);
        stepEdge();
        gnt    = 0;
        rvalid = 1;
        @(negedge clk);
        checkOutput("lbu_fwd", rd_value_mem, 32'h0000_0080);
        stepEdge();
        rvalid = 0;
        setIdle();
        @(negedge clk);
        checkOutput("lbu_wb_value", value_wb, 32'h0000_0080);

        // SH at 0x202 with grant withheld for three cycles
        stepEdge();
        applyStimulus(0, 1, 0, 0, 3'b001, 2'b00, 5'd0, 32'h0000_0202, 32'h1234_ABCD, 32'h0);
        stalls = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            checkOutput("sh_hold_req", 32'(req), 32'd1);
            checkOutput("sh_hold_addr", addr, 32'h0000_0202);
            checkOutput("sh_hold_wdata", wdata, 32'hABCD_ABCD);
            checkOutput("sh_hold_be", 32'(be), 32'hC);
            checkOutput("sh_hold_we", 32'(we), 32'd1);
            stepEdge();
        end
        gnt = 1;
        @(negedge clk);
        if (stall) stalls++;
        stepEdge();
        gnt    = 0;
        rvalid = 1;
        @(negedge clk);
        if (stall) stalls++;
        checkOutput("sh_stall_cycles", 32'(stalls), 32'd4);
        stepEdge();
        rvalid = 0;

        // SW forwarding the WB value
        applyStimulus(0, 0, 1, 0, 3'b000, 2'b00, 5'd3, 32'hDEAD_BEEF, 32'h0, 32'h0);
        stepEdge();
        applyStimulus(0, 1, 0, 1, 3'b010, 2'b00, 5'd0, 32'h0000_0300, 32'h1111_1111, 32'h0);
        gnt = 1;
        @(negedge clk);
        checkOutput("sw_fwd_wdata", wdata, 32'hDEAD_BEEF);
        checkOutput("sw_fwd_be", 32'(be), 32'hF);
        stepEdge();
        gnt    = 0;
        rvalid = 1;
        stepEdge();
        rvalid = 0;

        // LW at 0x401
        applyStimulus(1, 0, 1, 0, 3'b010, 2'b01, 5'd9, 32'h0000_0401, 32'h0, 32'h0);
        gnt   = 1;
        rdata = 32'hCAFE_0001;
        @(negedge clk);
`ifdef MEM_MISALIGN_TRAP_EN
        checkOutput("lw_mis_req", 32'(req), 32'd0);
        checkOutput("lw_mis_stall", 32'(stall), 32'd0);
        stepEdge();
        gnt = 0;
        setIdle();
        @(negedge clk);
        checkOutput("lw_mis_pulse", 32'(misalign), 32'd1);
        checkOutput("lw_mis_wen", 32'(wen_wb), 32'd0);
`else
        checkOutput("lw_mis_req", 32'(req), 32'd1);
        checkOutput("lw_mis_addr", addr, 32'h0000_0400);
        stepEdge();
        gnt    = 0;
        rvalid = 1;
        @(negedge clk);
        checkOutput("lw_mis_fwd", rd_value_mem, 32'hCAFE_0001);
        stepEdge();
        rvalid = 0;
        setIdle();
`endif

        for (int c = 0; c < 600; c++) begin
            stepEdge();
            if (!m_stall) randomInstr();
            gnt    = ($urandom_range(0, 2) != 0);
            rvalid = ($urandom_range(0, 2) == 0);
            rdata  = $urandom;
        end
        drained = 0;
        for (int c = 0; c < 50 && !drained; c++) begin
            stepEdge();
            gnt    = 1;
            rvalid = 1;
            if (!m_stall) begin
                setIdle();
                drained = 1;
            end
        end
        stepEdge();
        gnt    = 0;
        rvalid = 0;
        if (!drained) checkOutput("drain_timeout", 32'd0, 32'd1);

        // Reset while waiting for the response, then a late rvalid
        applyStimulus(0, 0, 1, 0, 3'b000, 2'b00, 5'd4, 32'h0000_5A5A, 32'h0, 32'h0);
        stepEdge();
        applyStimulus(1, 0, 1, 0, 3'b010, 2'b01, 5'd6, 32'h0000_0500, 32'h0, 32'h0);
        gnt = 1;
        @(negedge clk);
        checkOutput("rst_pre_req", 32'(req), 32'd1);
        checkOutput("rst_pre_value_wb", value_wb, 32'h0000_5A5A);
        stepEdge();
        gnt = 0;
        #2;
        setIdle();
        rst_n = 0;
        @(negedge clk);
        checkOutput("rst_mid_value_wb", value_wb, 32'd0);
        checkOutput("rst_mid_wen_wb", 32'(wen_wb), 32'd0);
        checkOutput("rst_mid_req", 32'(req), 32'd0);
        stepEdge();
        rst_n  = 1;
        rvalid = 1;
        rdata  = 32'h7777_7777;
        @(negedge clk);
        checkOutput("late_rvalid_stall", 32'(stall), 32'd0);
        checkOutput("late_rvalid_req", 32'(req), 32'd0);
        stepEdge();
        rvalid = 0;
        applyStimulus(1, 0, 1, 0, 3'b010, 2'b01, 5'd6, 32'h0000_0600, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("post_reset_req", 32'(req), 32'd1);
        checkOutput("post_reset_stall", 32'(stall), 32'd1);
        stepEdge();
        gnt = 1;
        stepEdge();
        gnt    = 0;
        rvalid = 1;
        stepEdge();
        rvalid = 0;
        setIdle();
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
